shared_bus_initiator: RTL and testbench

SHARED_BUS_INITIATOR -- requirements
Module: shared_bus_initiator

---
 rtl/shared_bus_initiator.sv | 201 ++++++++++++++++++++
 tb/tb_shared_bus_initiator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shared_bus_initiator.sv
// Three-requester round-robin initiator for a simple shared bus.
// It grants one requester, drives a registered read/write strobe, and returns a one-cycle ack.
module shared_bus_initiator #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  req_we,
  input  logic [23:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic [2:0]  ack,
  output logic [7:0]  resp_data,
  output logic        resp_err,
  output logic [7:0]  address,
  output logic        read,
  output logic        write,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  input  logic        ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [1:0]  ptr, ptr_n;
  logic [1:0]  gnt, gnt_n;
  logic        lat_we, lat_we_n;
  logic [7:0]  lat_addr, lat_addr_n;
  logic [7:0]  lat_wdata, lat_wdata_n;
  logic [3:0]  wait_cnt, wait_cnt_n;

  logic [2:0]  ack_n;
  logic [7:0]  resp_data_n;
  logic        resp_err_n;
  logic [7:0]  address_n;
  logic        read_n;
  logic        write_n;
  logic [7:0]  wdata_n;

  logic [1:0]  pick;
  logic [7:0]  pick_addr;
  logic [7:0]  pick_wdata;
  logic        pick_we;
  logic        pick_mapped;
  logic        timed_out;

  // Search order is ptr+1, ptr+2, ptr (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    case (p)
      2'd0:    rr_pick = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd1:    rr_pick = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: rr_pick = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
  endfunction

  function automatic logic [7:0] lane(input logic [23:0] v, input logic [1:0] i);
    case (i)
      2'd1:    lane = v[15:8];
      2'd2:    lane = v[23:16];
      default: lane = v[7:0];
    endcase
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] i);
    case (i)
      2'd1:    one_hot = 3'b010;
      2'd2:    one_hot = 3'b100;
      default: one_hot = 3'b001;
    endcase
  endfunction

  assign pick        = rr_pick(req, ptr);
  assign pick_addr   = lane(req_addr, pick);
  assign pick_wdata  = lane(req_wdata, pick);
  assign pick_we     = (pick == 2'd1) ? req_we[1] : ((pick == 2'd2) ? req_we[2] : req_we[0]);
  // Only the bottom four 16-byte windows (0x00..0x3F) have targets behind them.
  assign pick_mapped = (pick_addr[7:6] == 2'b00);
  assign timed_out   = (wait_cnt == LAST_WAIT);

  // State register: FSM state, grant context and the registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd2;
      gnt       <= 2'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 8'h00;
      lat_wdata <= 8'h00;
      wait_cnt  <= 4'd0;
      ack       <= 3'b000;
      resp_data <= 8'h00;
      resp_err  <= 1'b0;
      address   <= 8'h00;
      read      <= 1'b0;
      write     <= 1'b0;
      wdata     <= 8'h00;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt       <= gnt_n;
      lat_we    <= lat_we_n;
      lat_addr  <= lat_addr_n;
      lat_wdata <= lat_wdata_n;
      wait_cnt  <= wait_cnt_n;
      ack       <= ack_n;
      resp_data <= resp_data_n;
      resp_err  <= resp_err_n;
      address   <= address_n;
      read      <= read_n;
      write     <= write_n;
      wdata     <= wdata_n;
    end
  end

  // Next-state and grant-context logic.
  // NOTE: every variable gets a default at the top of the block so no path infers a latch.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    gnt_n       = gnt;
    lat_we_n    = lat_we;
    lat_addr_n  = lat_addr;
    lat_wdata_n = lat_wdata;
    wait_cnt_n  = wait_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n     = pick_mapped ? ISSUE : RESP;
          ptr_n       = pick;
          gnt_n       = pick;
          lat_we_n    = pick_we;
          lat_addr_n  = pick_addr;
          lat_wdata_n = pick_wdata;
          wait_cnt_n  = 4'd0;
        end
      end
      ISSUE: begin
        // ready wins over a timeout that lands on the same edge.
        if (ready || timed_out) begin
          state_n = RESP;
        end
        if (!ready) begin
          wait_cnt_n = wait_cnt + 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic: values the output registers take at the next edge.
  always_comb begin
    ack_n       = 3'b000;
    resp_data_n = 8'h00;
    resp_err_n  = 1'b0;
    address_n   = 8'h00;
    read_n      = 1'b0;
    write_n     = 1'b0;
    wdata_n     = 8'h00;
    case (state)
      IDLE: begin
        if (|req) begin
          if (pick_mapped) begin
            address_n = pick_addr;
            read_n    = !pick_we;
            write_n   = pick_we;
            wdata_n   = pick_we ? pick_wdata : 8'h00;
          end else begin
            ack_n      = one_hot(pick);
            resp_err_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (ready) begin
          ack_n       = one_hot(gnt);
          resp_data_n = lat_we ? 8'h00 : rdata;
        end else if (timed_out) begin
          ack_n      = one_hot(gnt);
          resp_err_n = 1'b1;
        end else begin
          address_n = lat_addr;
          read_n    = !lat_we;
          write_n   = lat_we;
          wdata_n   = lat_we ? lat_wdata : 8'h00;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_shared_bus_initiator.sv
// Directed bench for shared_bus_initiator: read, round-robin, unmapped, timeout,
// ready/timeout tie, write success and reset during an access.
module tb_shared_bus_initiator;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  req_we;
  logic [23:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  ack;
  logic [7:0]  resp_data;
  logic        resp_err;
  logic [7:0]  address;
  logic        read;
  logic        write;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;

  int checks = 0;
  int errors = 0;

  shared_bus_initiator #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .address   (address),
    .read      (read),
    .write     (write),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_read"},    32'(read),    32'h0);
    check({tag, "_write"},   32'(write),   32'h0);
    check({tag, "_address"}, 32'(address), 32'h0);
    check({tag, "_wdata"},   32'(wdata),   32'h0);
  endtask

  logic [1:0] rr_exp  [4];
  logic [7:0] rr_addr [3];
  int         strobe_cycles;
  int         prev;

  initial begin
    rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd0};
    rr_addr = '{8'h01, 8'h12, 8'h23};
    rst_n = 1'b1; req = 3'b000; req_we = 3'b000;
    req_addr = 24'h0; req_wdata = 24'h0; rdata = 8'h00; ready = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #12;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_resp_data", 32'(resp_data), 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check_idle_bus("rst");

    // Single read from requester 0; ready already high in IDLE is ignored
    @(negedge clk);
    rst_n = 1'b1;
    req = 3'b001; req_we = 3'b000; req_addr[7:0] = 8'h05; req_wdata[7:0] = 8'hDD;
    rdata = 8'hA5; ready = 1'b1;
    step();
    check("rd_read", 32'(read), 32'h1);
    check("rd_write", 32'(write), 32'h0);
    check("rd_address", 32'(address), 32'h05);
    check("rd_wdata", 32'(wdata), 32'h00);
    check("rd_ack_early", 32'(ack), 32'h0);
    step();
    check("rd_ack", 32'(ack), 32'b001);
    check("rd_resp_data", 32'(resp_data), 32'hA5);
    check("rd_resp_err", 32'(resp_err), 32'h0);
    check_idle_bus("rd_resp");
    step();
    check("rd_ack_drop", 32'(ack), 32'h0);
    req = 3'b000;

    // Reset asserted during ISSUE of a write from requester 1
    req = 3'b010; req_we = 3'b010; req_addr[15:8] = 8'h20; req_wdata[15:8] = 8'h77;
    ready = 1'b0;
    step();
    check("rm_write", 32'(write), 32'h1);
    check("rm_address", 32'(address), 32'h20);
    check("rm_wdata", 32'(wdata), 32'h77);
    #3 rst_n = 1'b0;
    #1;
    check_idle_bus("rm_async");
    req = 3'b000;
    step();
    check("rm_no_ack", 32'(ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with all three requesting: 0, 1, 2, 0
    req = 3'b111; req_we = 3'b000; ready = 1'b1;
    for (int i = 0; i < 3; i++) req_addr[8*i +: 8] = rr_addr[i];
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      rdata = 8'hC0 | 8'(rr_exp[i]);
      step();
      check($sformatf("rr%0d_address", i), 32'(address), 32'(rr_addr[rr_exp[i]]));
      check($sformatf("rr%0d_read", i), 32'(read), 32'h1);
      if (prev >= 0) req[prev] = 1'b1;
      step();
      check($sformatf("rr%0d_ack", i), 32'(ack), 32'(3'b001 << rr_exp[i]));
      check($sformatf("rr%0d_resp_data", i), 32'(resp_data), 32'(8'hC0 | 8'(rr_exp[i])));
      step();
      check($sformatf("rr%0d_ack_drop", i), 32'(ack), 32'h0);
      req[rr_exp[i]] = 1'b0;
      prev = int'(rr_exp[i]);
    end
    req = 3'b000;
    step();

    // Unmapped address from requester 1
    req = 3'b010; req_we = 3'b000; req_addr[15:8] = 8'h47; rdata = 8'h99; ready = 1'b1;
    step();
    check("um_ack", 32'(ack), 32'b010);
    check("um_resp_err", 32'(resp_err), 32'h1);
    check("um_resp_data", 32'(resp_data), 32'h00);
    check_idle_bus("um");
    step();
    check("um_ack_drop", 32'(ack), 32'h0);
    check_idle_bus("um_after");
    req = 3'b000;

    // Timeout: write from requester 2 with ready held low; inputs change mid-access
    req = 3'b100; req_we = 3'b100; req_addr[23:16] = 8'h12; req_wdata[23:16] = 8'h3C;
    ready = 1'b0;
    step();
    check("to_write", 32'(write), 32'h1);
    check("to_wdata", 32'(wdata), 32'h3C);
    req_addr[23:16] = 8'hFF; req_wdata[23:16] = 8'h00; req = 3'b111;
    strobe_cycles = 1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (write !== 1'b1) break;
      strobe_cycles++;
      if (n == 8) begin
        check("to_hold_address", 32'(address), 32'h12);
        check("to_hold_wdata", 32'(wdata), 32'h3C);
      end
    end
    check("to_strobe_cycles", 32'(strobe_cycles), 32'd15);
    check("to_ack", 32'(ack), 32'b100);
    check("to_resp_err", 32'(resp_err), 32'h1);
    check("to_resp_data", 32'(resp_data), 32'h00);
    req = 3'b000;
    step();
    check("to_ack_drop", 32'(ack), 32'h0);

    // Tie: ready arrives on the 15th ISSUE edge of a read from requester 0
    req = 3'b001; req_we = 3'b000; req_addr[7:0] = 8'h30; rdata = 8'h5A; ready = 1'b0;
    step();
    for (int n = 0; n < 14; n++) step();
    check("tie_read_still", 32'(read), 32'h1);
    ready = 1'b1;
    step();
    check("tie_ack", 32'(ack), 32'b001);
    check("tie_resp_err", 32'(resp_err), 32'h0);
    check("tie_resp_data", 32'(resp_data), 32'h5A);
    step();
    req = 3'b000;

    // Write success: resp_data reads as zero even with rdata driven
    req = 3'b010; req_we = 3'b010; req_addr[15:8] = 8'h2B; req_wdata[15:8] = 8'h99;
    rdata = 8'hEE; ready = 1'b1;
    step();
    check("wr_write", 32'(write), 32'h1);
    check("wr_read", 32'(read), 32'h0);
    check("wr_wdata", 32'(wdata), 32'h99);
    step();
    check("wr_ack", 32'(ack), 32'b010);
    check("wr_resp_data", 32'(resp_data), 32'h00);
    check("wr_resp_err", 32'(resp_err), 32'h0);
    step();
    req = 3'b000;
    step();
    check("end_ack", 32'(ack), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
